// File: rtl/input_debounce_if.sv
// Signal bundle between the raw quadrature input pins and the debounced outputs feeding the decoder.
// The optional bypass control exists only when DEBOUNCE_BYPASS_EN is defined.
interface input_debounce_if #(
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0] din;
  logic [CHANNELS-1:0] dout;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic                busy;
`ifdef DEBOUNCE_BYPASS_EN
  logic                bypass;
`endif

  modport master (
`ifdef DEBOUNCE_BYPASS_EN
    output bypass,
`endif
    output din,
    input  dout, rise, fall, busy
  );

  modport slave (
`ifdef DEBOUNCE_BYPASS_EN
    input  bypass,
`endif
    input  din,
    output dout, rise, fall, busy
  );
endinterface

// File: rtl/input_debounce.sv
// Per-channel 2-flop synchronizer plus tick-based stability filter for the raw quadrature input pins.
// Optional DEBOUNCE_BYPASS_EN adds a bypass input that passes synchronized levels straight through.
module input_debounce #(
  parameter int   CHANNELS     = 2,
  parameter int   PRESCALE     = 16,
  parameter int   STABLE_COUNT = 8,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input_debounce_if.slave   bus
);

  localparam int CW = ($clog2(STABLE_COUNT + 1) < 1) ? 1 : $clog2(STABLE_COUNT + 1);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_COUNT - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [CHANNELS-1:0] s1_q, s2_q;
  logic [PW-1:0]       pre_q, pre_d;
  logic                tick;
  logic                bypass_on;
  logic [CHANNELS-1:0] dout_w, rise_w, fall_w, busy_vec;

`ifdef DEBOUNCE_BYPASS_EN
  assign bypass_on = bus.bypass;
`else
  assign bypass_on = 1'b0;
`endif

  always_comb begin
    pre_d = pre_q + PW'(1);
    tick  = (pre_q == PRE_LAST);
    if (tick) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= {CHANNELS{RESET_LEVEL}};
      s2_q  <= {CHANNELS{RESET_LEVEL}};
      pre_q <= '0;
    end else begin
      s1_q  <= bus.din;
      s2_q  <= s1_q;
      pre_q <= pre_d;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dout_q, dout_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    always_comb begin
      cnt_d  = cnt_q;
      dout_d = dout_q;
      if (bypass_on) begin
        cnt_d  = '0;
        dout_d = s2_q[gi];
      end else if (tick) begin
        // Any sample back at the current level restarts the whole window.
        if (s2_q[gi] == dout_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          dout_d = s2_q[gi];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      rise_d = dout_d & ~dout_q;
      fall_d = ~dout_d & dout_q;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q  <= '0;
        dout_q <= RESET_LEVEL;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        dout_q <= dout_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign dout_w[gi]   = dout_q;
    assign rise_w[gi]   = rise_q;
    assign fall_w[gi]   = fall_q;
    assign busy_vec[gi] = (cnt_q != '0) && !bypass_on;
  end

  assign bus.dout = dout_w;
  assign bus.rise = rise_w;
  assign bus.fall = fall_w;
  assign bus.busy = |busy_vec;

endmodule

// File: tb/tb_input_debounce.sv
// Scoreboard bench for input_debounce: dut_a (PRESCALE=1, STABLE_COUNT=4), dut_b (PRESCALE=4, STABLE_COUNT=2).
module tb_input_debounce;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  input_debounce_if #(.CHANNELS(2)) if_a ();
  input_debounce_if #(.CHANNELS(2)) if_b ();

  input_debounce #(.CHANNELS(2), .PRESCALE(1), .STABLE_COUNT(4), .RESET_LEVEL(1'b0)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave)
  );
  input_debounce #(.CHANNELS(2), .PRESCALE(4), .STABLE_COUNT(2), .RESET_LEVEL(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave)
  );

  typedef struct packed {
    logic [1:0] dout;
    logic [1:0] rise;
    logic [1:0] fall;
    logic       busy;
  } obs_t;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];

  function automatic obs_t obs_a();
    obs_a = {if_a.dout, if_a.rise, if_a.fall, if_a.busy};
  endfunction

  function automatic obs_t obs_b();
    obs_b = {if_b.dout, if_b.rise, if_b.fall, if_b.busy};
  endfunction

  // Expected dut_a trace for one full window with PRESCALE=1, STABLE_COUNT=4, input changed before edge k.
  task automatic push_window(input logic [1:0] old_v, input logic [1:0] new_v);
    exp_q.push_back({old_v, 2'b00, 2'b00, 1'b0});
    exp_q.push_back({old_v, 2'b00, 2'b00, 1'b0});
    repeat (3) exp_q.push_back({old_v, 2'b00, 2'b00, 1'b1});
    exp_q.push_back({new_v, new_v & ~old_v, old_v & ~new_v, 1'b0});
    exp_q.push_back({new_v, 2'b00, 2'b00, 1'b0});
  endtask

  task automatic test_reset();
    obs_t e, g;
    reset = 1'b1;
    if_a.din = 2'b00;
    if_b.din = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    e = '0;
    g = obs_a();
    checks++;
    if (g !== e) begin errors++; $display("FAIL reset_a: got %b expected %b", g, e); end
    g = obs_b();
    checks++;
    if (g !== e) begin errors++; $display("FAIL reset_b: got %b expected %b", g, e); end
    reset = 1'b0;
    @(posedge clk);
    #1;
    g = obs_a();
    checks++;
    if (g !== e) begin errors++; $display("FAIL reset_idle: got %b expected %b", g, e); end
    $display("test_reset done");
  endtask

  task automatic test_rise();
    obs_t e, g;
    int   n = 0;
    if_a.din = 2'b01;
    push_window(2'b00, 2'b01);
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      g = obs_a();
      checks++;
      if (g !== e) begin errors++; $display("FAIL rise cyc%0d: got %b expected %b", n, g, e); end
      n++;
    end
    $display("test_rise done");
  endtask

  task automatic test_glitch();
    obs_t e, g;
    if_a.din = 2'b11;
    exp_q.push_back({2'b01, 2'b00, 2'b00, 1'b0});
    exp_q.push_back({2'b01, 2'b00, 2'b00, 1'b0});
    repeat (3) exp_q.push_back({2'b01, 2'b00, 2'b00, 1'b1});
    repeat (3) exp_q.push_back({2'b01, 2'b00, 2'b00, 1'b0});
    for (int n = 0; exp_q.size() > 0; n++) begin
      if (n == 3) if_a.din = 2'b01;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      g = obs_a();
      checks++;
      if (g !== e) begin errors++; $display("FAIL glitch cyc%0d: got %b expected %b", n, g, e); end
    end
    $display("test_glitch done");
  endtask

  task automatic test_fall();
    obs_t e, g;
    int   n = 0;
    if_a.din = 2'b00;
    push_window(2'b01, 2'b00);
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      g = obs_a();
      checks++;
      if (g !== e) begin errors++; $display("FAIL fall cyc%0d: got %b expected %b", n, g, e); end
      n++;
    end
    $display("test_fall done");
  endtask

  task automatic test_simultaneous();
    obs_t e, g;
    int   n = 0;
    if_a.din = 2'b11;
    push_window(2'b00, 2'b11);
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      g = obs_a();
      checks++;
      if (g !== e) begin errors++; $display("FAIL simul cyc%0d: got %b expected %b", n, g, e); end
      n++;
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_reset_mid();
    obs_t e, g;
    reset = 1'b1;
    if_a.din = 2'b00;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    // Partial window: counter reaches 2 after the fourth edge.
    if_a.din = 2'b01;
    exp_q.push_back({2'b00, 2'b00, 2'b00, 1'b0});
    exp_q.push_back({2'b00, 2'b00, 2'b00, 1'b0});
    exp_q.push_back({2'b00, 2'b00, 2'b00, 1'b1});
    exp_q.push_back({2'b00, 2'b00, 2'b00, 1'b1});
    exp_q.push_back({2'b00, 2'b00, 2'b00, 1'b0});
    push_window(2'b00, 2'b01);
    for (int n = 0; exp_q.size() > 0; n++) begin
      reset = (n == 4);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      g = obs_a();
      checks++;
      if (g !== e) begin errors++; $display("FAIL reset_mid cyc%0d: got %b expected %b", n, g, e); end
    end
    reset = 1'b0;
    $display("test_reset_mid done");
  endtask

  task automatic test_prescale();
    obs_t e, g;
    int   first = 0;
    int   rise_cnt = 0;
    int   rise_at = 0;
    int   fall_cnt = 0;
    if_b.din = 2'b01;
    exp_q.push_back({2'b01, 2'b00, 2'b00, 1'b0});
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk);
      #1;
      if (if_b.dout[0] && first == 0) first = c;
      if (if_b.rise != 2'b00) begin rise_cnt++; rise_at = c; end
      if (if_b.fall != 2'b00) fall_cnt++;
    end
    checks++;
    if (first < 7 || first > 10) begin errors++; $display("FAIL prescale_latency: got %0d expected 7..10", first); end
    checks++;
    if (rise_cnt != 1 || rise_at != first) begin
      errors++; $display("FAIL prescale_rise: got count %0d at %0d expected 1 at %0d", rise_cnt, rise_at, first);
    end
    checks++;
    if (fall_cnt != 0) begin errors++; $display("FAIL prescale_fall: got %0d expected 0", fall_cnt); end
    e = exp_q.pop_front();
    g = obs_b();
    checks++;
    if (g !== e) begin errors++; $display("FAIL prescale_final: got %b expected %b", g, e); end
    $display("test_prescale done (latency %0d)", first);
  endtask

`ifdef DEBOUNCE_BYPASS_EN
  task automatic test_bypass();
    obs_t       e, g;
    logic [1:0] hist[$];
    logic [1:0] v, prev;
    if_a.bypass = 1'b1;
    if_a.din    = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    prev = 2'b00;
    for (int n = 0; n < 10; n++) begin
      v = (n % 2 == 0) ? 2'b01 : 2'b00;
      if_a.din = v;
      hist.push_back(v);
      if (hist.size() >= 3) begin
        e = {hist[hist.size()-3], hist[hist.size()-3] & ~prev, prev & ~hist[hist.size()-3], 1'b0};
        prev = hist[hist.size()-3];
      end else begin
        e = {2'b00, 2'b00, 2'b00, 1'b0};
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      g = obs_a();
      checks++;
      if (g !== e) begin errors++; $display("FAIL bypass cyc%0d: got %b expected %b", n, g, e); end
    end
    if_a.bypass = 1'b0;
    $display("test_bypass done");
  endtask
`endif

  initial begin
`ifdef DEBOUNCE_BYPASS_EN
    if_a.bypass = 1'b0;
    if_b.bypass = 1'b0;
`endif
    test_reset();
    test_rise();
    test_glitch();
    test_fall();
    test_simultaneous();
    test_reset_mid();
    test_prescale();
`ifdef DEBOUNCE_BYPASS_EN
    test_bypass();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
